bp_clint_slice: RTL and testbench
=================================

Name: bp_clint_slice

Overview:
- Memory-mapped core-local interruptor (CLINT) that services the device window at physical 0x02xx_xxxx, downstream of the uncached/IO command router that decodes the platform address map.
- Holds per-core MSIP bits and mtimecmp registers, plus the shared mtime counter.
- Drives per-core software and timer interrupt lines into the BE CSR/interrupt logic.
- Single outstanding request; fixed one-cycle response latency.

Parameters:
- num_core_p, 1, number of harts served (1..16).
- paddr_width_p, 56, physical address width (bp_sv39_paddr_width_gp).
- data_width_p, 64, command/response data width (fixed at 64).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cmd_v_i  in  1  command valid
- cmd_ready_o  out  1  block can accept a command this cycle
- cmd_addr_i  in  paddr_width_p  byte address
- cmd_w_i  in  1  1=write, 0=read
- cmd_size_i  in  2  2'b10=4B, 2'b11=8B; other encodings illegal
- cmd_data_i  in  64  write data (4B writes use bits [31:0])
- resp_v_o  out  1  response valid
- resp_yumi_i  in  1  consumer takes response (only legal while resp_v_o=1)
- resp_data_o  out  64  read data (0 for writes and errors)
- resp_err_o  out  1  access fault
- rtc_tick_i  in  1  mtime increment strobe
- soft_irq_o  out  num_core_p  MSIP[i]
- timer_irq_o  out  num_core_p  registered (mtime >= mtimecmp[i])

Behaviour:
- Reset values:
  - mtime=0; mtimecmp[i]=64'hFFFF_FFFF_FFFF_FFFF; msip[i]=0.
  - soft_irq_o=0, timer_irq_o=0, resp_v_o=0, resp_data_o=0, resp_err_o=0, cmd_ready_o=1 in the first cycle after reset.
- FSM has two states, READY and RESP.
  - READY: cmd_ready_o=1. On cmd_v_i, latch the response, perform any register write at that clock edge, then go to RESP.
  - RESP: cmd_ready_o=0; resp_v_o=1, with data/err stable until resp_yumi_i. On yumi, return to READY. The next command can be accepted in the cycle after yumi; there is no same-cycle bypass.
- Latency: a command accepted at edge N gives resp_v_o=1 from cycle N+1.
- Address decode:
  - Hit requires addr[paddr_width_p-1:24]==8'h02. Offset is off=addr[23:0].
  - msip[i] at off=0x0000+4*i, 4B accesses only.
  - mtimecmp[i] at off=0x4000+8*i.
  - mtime at off=0xBFF8.
  - 4B access: addr[1:0]==0; addr[2] selects the upper or lower half.
  - 8B access: addr[2:0]==0.
- Errors: resp_err_o=1, no state change, resp_data_o=0. Causes:
  - misalignment;
  - illegal size;
  - 8B access to the msip region;
  - core index >= num_core_p;
  - any other offset;
  - non-0x02 upper bits.
- Reads: 8B returns the full register. 4B returns the selected half zero-extended into [31:0]. msip reads return {63'b0, msip[i]}.
- Writes:
  - 8B writes the full register.
  - 4B writes only the selected 32-bit half; the other half is unchanged.
  - msip write: bit0 is stored, other bits are ignored.
- mtime advance: mtime increments by 1 (64-bit wrap 2^64-1 -> 0) at each edge where rtc_tick_i=1.
  - A write to mtime in the same cycle as a tick wins: the written half takes the write data, and no increment is applied to that update.
  - For a 4B write, the untouched half holds its pre-tick value.
- Timer interrupt: timer_irq_o[i] <= (mtime >= mtimecmp[i]), an unsigned compare using current register values. It lags any register change by one cycle.
- Soft interrupt: soft_irq_o[i] = msip[i] register. It is visible the cycle after the write edge.
- Illegal yumi (without resp_v_o) is ignored.
- Reset asserted mid-transaction drops the pending response: resp_v_o=0 next cycle, and all registers return to reset values.

Test Plan:
- Reset, then idle 3 cycles -> timer_irq_o=0, soft_irq_o=0, cmd_ready_o=1, resp_v_o=0.
- 8B write mtimecmp[0] (addr 0x0200_4000) = 5, hold rtc_tick_i=1 from mtime=0 -> timer_irq_o[0] rises the cycle after mtime reaches 5. A subsequent read of 0x0200_BFF8 returns ≥5.
- 4B write 0x0200_4004 = 0x1234 after mtimecmp[0]=0 -> 8B read of 0x0200_4000 returns 0x0000_1234_0000_0000.
- Write msip[0] (0x0200_0000, 4B) = 0xFFFF_FFFF -> soft_irq_o[0]=1; read returns 1. Write 0 -> soft_irq_o[0]=0.
- Error accesses, each giving resp_err_o=1, data 0, and no register change:
  - 8B read of 0x0200_0000;
  - 4B read of 0x0200_4002;
  - read of 0x0300_0000;
  - msip index = num_core_p.
- 8B write mtime=64'hFFFF_FFFF_FFFF_FFFF with tick=1 in the following cycle -> mtime=0.
- Tick coincident with an mtime write of 100 -> mtime=100, not 101.
- Handshake: hold resp_yumi_i=0 for 4 cycles -> resp_v_o and data stay stable and cmd_ready_o=0. After yumi, the next command is accepted the following cycle.
- Assert reset_i during RESP -> resp_v_o=0 next cycle; registers return to reset values.

Source files
------------

// File: rtl/bp_clint_slice.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_clint_slice : core-local interruptor (msip, mtimecmp, mtime) behind a  |
// |                  single-outstanding, one-cycle-latency command port.      |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module bp_clint_slice #(
  parameter int num_core_p    = 1,
  parameter int paddr_width_p = 56,
  parameter int data_width_p  = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic [paddr_width_p-1:0] cmd_addr_i,
  input  logic                     cmd_w_i,
  input  logic [1:0]               cmd_size_i,
  input  logic [data_width_p-1:0]  cmd_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic [data_width_p-1:0]  resp_data_o,
  output logic                     resp_err_o,
  input  logic                     rtc_tick_i,
  output logic [num_core_p-1:0]    soft_irq_o,
  output logic [num_core_p-1:0]    timer_irq_o
);

  localparam logic [paddr_width_p-25:0] c_dev_base   = (paddr_width_p-24)'(8'h02);
  localparam logic [11:0]               c_ncore_msip = 12'(num_core_p);
  localparam logic [10:0]               c_ncore_mtc  = 11'(num_core_p);
  localparam logic [20:0]               c_mtime_dw   = 21'h17FF;

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_RESP  = 1'b1
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  w_accept;

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp [num_core_p];
  logic [num_core_p-1:0] r_msip;
  logic [num_core_p-1:0] r_timer;
  logic [63:0]           r_resp_data;
  logic                  r_resp_err;

  logic [23:0]           w_off;
  logic [11:0]           w_msip_idx;
  logic [10:0]           w_mtc_idx;
  logic                  w_base_hit;
  logic                  w_size_ok;
  logic                  w_is8;
  logic                  w_align_ok;
  logic                  w_msip_hit;
  logic                  w_mtc_hit;
  logic                  w_mtime_hit;
  logic                  w_err;
  logic                  w_do_wr;
  logic [63:0]           w_cur;
  logic [63:0]           w_rd_data;
  logic [63:0]           w_wr_val;

  // Address decode: every failure mode collapses into a single error flag.
  always_comb begin
    w_off       = cmd_addr_i[23:0];
    w_base_hit  = (cmd_addr_i[paddr_width_p-1:24] == c_dev_base);
    w_size_ok   = cmd_size_i[1];
    w_is8       = cmd_size_i[0];
    w_align_ok  = w_is8 ? (cmd_addr_i[2:0] == 3'b000) : (cmd_addr_i[1:0] == 2'b00);
    w_msip_idx  = w_off[13:2];
    w_mtc_idx   = w_off[13:3];
    w_msip_hit  = (w_off[23:14] == 10'd0) && !w_is8 && (w_msip_idx < c_ncore_msip);
    w_mtc_hit   = (w_off[23:14] == 10'd1) && (w_mtc_idx < c_ncore_mtc);
    w_mtime_hit = (w_off[23:3] == c_mtime_dw);
    w_err       = !(w_base_hit && w_size_ok && w_align_ok &&
                    (w_msip_hit || w_mtc_hit || w_mtime_hit));
    w_do_wr     = w_accept && cmd_w_i && !w_err;
  end

  // Current value of the addressed register, used for reads and half-merges.
  always_comb begin
    w_cur = 64'd0;
    if (w_mtime_hit) begin
      w_cur = r_mtime;
    end
    for (int i = 0; i < num_core_p; i++) begin
      if (w_msip_hit && (w_msip_idx == 12'(i))) begin
        w_cur = {63'd0, r_msip[i]};
      end
      if (w_mtc_hit && (w_mtc_idx == 11'(i))) begin
        w_cur = r_mtimecmp[i];
      end
    end
  end

  always_comb begin
    w_rd_data = 64'd0;
    if (!w_err && !cmd_w_i) begin
      if (w_is8 || w_msip_hit) begin
        w_rd_data = w_cur;
      end else if (cmd_addr_i[2]) begin
        w_rd_data = {32'd0, w_cur[63:32]};
      end else begin
        w_rd_data = {32'd0, w_cur[31:0]};
      end
    end
    if (w_is8) begin
      w_wr_val = cmd_data_i[63:0];
    end else if (cmd_addr_i[2]) begin
      w_wr_val = {cmd_data_i[31:0], w_cur[31:0]};
    end else begin
      w_wr_val = {w_cur[63:32], cmd_data_i[31:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_READY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready_o = 1'b0;
    resp_v_o    = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_READY: begin
        cmd_ready_o = 1'b1;
        if (cmd_v_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_v_o = 1'b1;
        if (resp_yumi_i) begin
          w_state_nxt = ST_READY;
        end
      end
      default: w_state_nxt = ST_READY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_resp_data <= 64'd0;
      r_resp_err  <= 1'b0;
    end else if (w_accept) begin
      r_resp_data <= w_rd_data;
      r_resp_err  <= w_err;
    end
  end

  // A write beats a coincident tick; the untouched half keeps its pre-tick value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mtime <= 64'd0;
    end else if (w_do_wr && w_mtime_hit) begin
      r_mtime <= w_wr_val;
    end else if (rtc_tick_i) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_core_p; i++) begin
        r_mtimecmp[i] <= '1;
      end
      r_msip  <= '0;
      r_timer <= '0;
    end else begin
      for (int i = 0; i < num_core_p; i++) begin
        if (w_do_wr && w_mtc_hit && (w_mtc_idx == 11'(i))) begin
          r_mtimecmp[i] <= w_wr_val;
        end
        if (w_do_wr && w_msip_hit && (w_msip_idx == 12'(i))) begin
          r_msip[i] <= cmd_data_i[0];
        end
        r_timer[i] <= (r_mtime >= r_mtimecmp[i]);
      end
    end
  end

  assign resp_data_o = r_resp_data;
  assign resp_err_o  = r_resp_err;
  assign soft_irq_o  = r_msip;
  assign timer_irq_o = r_timer;

endmodule
`default_nettype wire

// File: tb/tb_bp_clint_slice.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bp_clint_slice : vector table plus corner sequences for bp_clint_slice |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_bp_clint_slice;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_v_i = 1'b0;
  logic        cmd_ready_o;
  logic [55:0] cmd_addr_i = '0;
  logic        cmd_w_i = 1'b0;
  logic [1:0]  cmd_size_i = 2'b11;
  logic [63:0] cmd_data_i = '0;
  logic        resp_v_o;
  logic        resp_yumi_i = 1'b0;
  logic [63:0] resp_data_o;
  logic        resp_err_o;
  logic        rtc_tick_i = 1'b0;
  logic [0:0]  soft_irq_o;
  logic [0:0]  timer_irq_o;

  always #5 clk = ~clk;

  bp_clint_slice #(.num_core_p(1), .paddr_width_p(56), .data_width_p(64)) dut (
    .clk_i(clk), .reset_i(reset_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_w_i(cmd_w_i), .cmd_size_i(cmd_size_i),
    .cmd_data_i(cmd_data_i), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o), .rtc_tick_i(rtc_tick_i),
    .soft_irq_o(soft_irq_o), .timer_irq_o(timer_irq_o)
  );

  typedef struct {
    bit          w;
    logic [1:0]  sz;
    logic [55:0] addr;
    logic [63:0] data;
    logic [63:0] exp_data;
    bit          exp_err;
    bit          exp_soft;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    bit          e;
    string       tag;
  } sb_t;

  vec_t tbl[27];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic pop_chk();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_empty: got response with no expectation want queued entry");
      return;
    end
    e = sb_q.pop_front();
    chk({e.tag, "_data"}, resp_data_o, e.d);
    chk1({e.tag, "_err"}, resp_err_o, e.e);
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic do_cmd(input bit w, input logic [1:0] sz, input logic [55:0] a,
                        input logic [63:0] d, input logic [63:0] ed, input bit ee,
                        input bit tk_acc, input bit tk_yumi, input string tag);
    int n;
    sb_q.push_back('{ed, ee, tag});
    n = 0;
    while (!cmd_ready_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_ready_timeout: got ready=0 want ready=1", tag);
      void'(sb_q.pop_back());
      return;
    end
    cmd_v_i = 1'b1; cmd_w_i = w; cmd_size_i = sz; cmd_addr_i = a; cmd_data_i = d;
    rtc_tick_i = tk_acc;
    @(posedge clk); #1;
    cmd_v_i = 1'b0; rtc_tick_i = 1'b0;
    chk1({tag, "_latency"}, resp_v_o, 1'b1);
    n = 0;
    while (!resp_v_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!resp_v_o) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_resp_timeout: got resp_v=0 want resp_v=1", tag);
      void'(sb_q.pop_front());
      return;
    end
    pop_chk();
    resp_yumi_i = 1'b1; rtc_tick_i = tk_yumi;
    @(posedge clk); #1;
    resp_yumi_i = 1'b0; rtc_tick_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 2'b11, 56'h0200BFF8, 64'h0, 64'h0, 0, 0};
    tbl[1]  = '{0, 2'b11, 56'h02004000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0};
    tbl[2]  = '{0, 2'b10, 56'h02004004, 64'h0, 64'h0000_0000_FFFF_FFFF, 0, 0};
    tbl[3]  = '{1, 2'b11, 56'h02004000, 64'h0, 64'h0, 0, 0};
    tbl[4]  = '{1, 2'b10, 56'h02004004, 64'h1234, 64'h0, 0, 0};
    tbl[5]  = '{0, 2'b11, 56'h02004000, 64'h0, 64'h0000_1234_0000_0000, 0, 0};
    tbl[6]  = '{0, 2'b10, 56'h02004000, 64'h0, 64'h0, 0, 0};
    tbl[7]  = '{1, 2'b10, 56'h02000000, 64'hFFFF_FFFF, 64'h0, 0, 1};
    tbl[8]  = '{0, 2'b10, 56'h02000000, 64'h0, 64'h1, 0, 1};
    tbl[9]  = '{0, 2'b11, 56'h02000000, 64'h0, 64'h0, 1, 1};
    tbl[10] = '{0, 2'b10, 56'h02004002, 64'h0, 64'h0, 1, 1};
    tbl[11] = '{0, 2'b10, 56'h03000000, 64'h0, 64'h0, 1, 1};
    tbl[12] = '{0, 2'b10, 56'h02000004, 64'h0, 64'h0, 1, 1};
    tbl[13] = '{1, 2'b11, 56'h02000000, 64'h0, 64'h0, 1, 1};
    tbl[14] = '{0, 2'b01, 56'h0200BFF8, 64'h0, 64'h0, 1, 1};
    tbl[15] = '{0, 2'b10, 56'h01_0000_0200_0000, 64'h0, 64'h0, 1, 1};
    tbl[16] = '{1, 2'b10, 56'h02004008, 64'h55, 64'h0, 1, 1};
    tbl[17] = '{0, 2'b11, 56'h02004000, 64'h0, 64'h0000_1234_0000_0000, 0, 1};
    tbl[18] = '{1, 2'b10, 56'h02000000, 64'hFFFF_FFFE, 64'h0, 0, 0};
    tbl[19] = '{0, 2'b10, 56'h02000000, 64'h0, 64'h0, 0, 0};
    tbl[20] = '{1, 2'b10, 56'h0200BFFC, 64'hAB, 64'h0, 0, 0};
    tbl[21] = '{0, 2'b11, 56'h0200BFF8, 64'h0, 64'h0000_00AB_0000_0000, 0, 0};
    tbl[22] = '{0, 2'b10, 56'h0200BFFC, 64'h0, 64'hAB, 0, 0};
    tbl[23] = '{0, 2'b10, 56'h0200BFF8, 64'h0, 64'h0, 0, 0};
    tbl[24] = '{1, 2'b11, 56'h0200BFF8, 64'h0, 64'h0, 0, 0};
    tbl[25] = '{0, 2'b11, 56'h0200BFFC, 64'h0, 64'h0, 1, 0};
    tbl[26] = '{0, 2'b10, 56'h0200C000, 64'h0, 64'h0, 1, 0};

    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_timer", timer_irq_o[0], 1'b0);
    chk1("rst_soft", soft_irq_o[0], 1'b0);
    chk1("rst_ready", cmd_ready_o, 1'b1);
    chk1("rst_resp_v", resp_v_o, 1'b0);

    for (int i = 0; i < 27; i++) begin
      do_cmd(tbl[i].w, tbl[i].sz, tbl[i].addr, tbl[i].data, tbl[i].exp_data,
             tbl[i].exp_err, 1'b0, 1'b0, $sformatf("vec%0d", i));
      chk1($sformatf("vec%0d_soft", i), soft_irq_o[0], tbl[i].exp_soft);
    end

    // Timer: compare value 5, mtime counting from 0 on every edge.
    do_cmd(1, 2'b11, 56'h02004000, 64'd5, 64'd0, 0, 0, 0, "cmp5");
    rtc_tick_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk1($sformatf("timer_k%0d", k), timer_irq_o[0], (k >= 6));
    end
    rtc_tick_i = 1'b0;
    do_cmd(0, 2'b11, 56'h0200BFF8, 64'd0, 64'd10, 0, 0, 0, "mtime10");

    do_cmd(1, 2'b11, 56'h0200BFF8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 1, "wrapwr");
    do_cmd(0, 2'b11, 56'h0200BFF8, 64'd0, 64'd0, 0, 0, 0, "wraprd");
    do_cmd(1, 2'b11, 56'h0200BFF8, 64'd100, 64'd0, 0, 1, 0, "coinc_wr");
    do_cmd(0, 2'b11, 56'h0200BFF8, 64'd0, 64'd100, 0, 0, 0, "coinc_rd");
    do_cmd(1, 2'b10, 56'h0200BFFC, 64'd7, 64'd0, 0, 1, 0, "coinc4_wr");
    do_cmd(0, 2'b11, 56'h0200BFF8, 64'd0, 64'h0000_0007_0000_0064, 0, 0, 0, "coinc4_rd");

    resp_yumi_i = 1'b1;
    @(posedge clk); #1;
    resp_yumi_i = 1'b0;
    chk1("bad_yumi_v", resp_v_o, 1'b0);
    chk1("bad_yumi_ready", cmd_ready_o, 1'b1);

    // Stalled response; a write offered during RESP must be ignored.
    sb_q.push_back('{64'd5, 1'b0, "hs"});
    cmd_v_i = 1'b1; cmd_w_i = 1'b0; cmd_size_i = 2'b11; cmd_addr_i = 56'h02004000;
    @(posedge clk); #1;
    cmd_w_i = 1'b1; cmd_data_i = 64'd9;
    for (int k = 0; k < 4; k++) begin
      chk1("hs_v", resp_v_o, 1'b1);
      chk("hs_data", resp_data_o, 64'd5);
      chk1("hs_ready", cmd_ready_o, 1'b0);
      @(posedge clk); #1;
    end
    cmd_v_i = 1'b0;
    if (resp_v_o) pop_chk();
    else begin
      n_cmp++; n_bad++;
      $display("FAIL hs_lost: got resp_v=0 want resp_v=1");
      void'(sb_q.pop_front());
    end
    resp_yumi_i = 1'b1;
    @(posedge clk); #1;
    resp_yumi_i = 1'b0;
    chk1("hs_ready_after", cmd_ready_o, 1'b1);
    do_cmd(0, 2'b11, 56'h02004000, 64'd0, 64'd5, 0, 0, 0, "hs_next");

    // Reset while a response is pending.
    do_cmd(1, 2'b10, 56'h02000000, 64'd1, 64'd0, 0, 0, 0, "pre_msip");
    do_cmd(1, 2'b11, 56'h0200BFF8, 64'd100, 64'd0, 0, 0, 0, "pre_mtime");
    cmd_v_i = 1'b1; cmd_w_i = 1'b0; cmd_size_i = 2'b11; cmd_addr_i = 56'h0200BFF8;
    @(posedge clk); #1;
    cmd_v_i = 1'b0;
    chk1("mid_v", resp_v_o, 1'b1);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    chk1("mid_rst_v", resp_v_o, 1'b0);
    chk1("mid_rst_soft", soft_irq_o[0], 1'b0);
    chk("mid_rst_data", resp_data_o, 64'd0);
    @(posedge clk); #1;
    chk1("mid_rst_timer", timer_irq_o[0], 1'b0);
    chk1("mid_rst_ready", cmd_ready_o, 1'b1);
    do_cmd(0, 2'b11, 56'h02004000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, "post_cmp");
    do_cmd(0, 2'b10, 56'h02000000, 64'd0, 64'd0, 0, 0, 0, "post_msip");
    do_cmd(0, 2'b11, 56'h0200BFF8, 64'd0, 64'd0, 0, 0, 0, "post_mtime");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
